rx_seq_log: RTL and testbench



---
 rtl/rx_seq_log.sv | 67 ++++++
 tb/tb_rx_seq_log.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rx_seq_log.sv
// rx_seq_log: RX frame counter and 24-bit sequence checker with a sticky finished flag.
// Define LOG_SATURATE_EN to make countp/okp saturate at all-ones instead of wrapping.
module rx_seq_log #(
   parameter int SEQ_OFFSET = 3,
   parameter int CNT_W      = 32
) (
   input  logic             clk125MHz,
   input  logic             rst,
   input  logic             rx_en,
   input  logic [7:0]       rx_data,
   output logic [CNT_W-1:0] countp,
   output logic [CNT_W-1:0] okp,
   output logic             started,
   output logic             finished,
   output logic             valid
);
   localparam int IW = $clog2(SEQ_OFFSET + 4);
   localparam logic [IW-1:0] OFF = IW'(SEQ_OFFSET);
   localparam logic [IW-1:0] SAT = IW'(SEQ_OFFSET + 3);
   logic [IW-1:0] idx;
   logic [23:0]   seq, last_seq;
   logic          prev_en, skip, first;
   logic          in_seq, accept, seq_ok, seq_back;
   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
`ifdef LOG_SATURATE_EN
      return &v ? v : v + 1'b1;
`else
      return v + 1'b1;
`endif
   endfunction
   always_comb begin
      in_seq   = rx_en && !skip && idx >= OFF && idx < SAT;
      accept   = prev_en && !rx_en && idx == SAT && !finished;
      seq_ok   = first || seq == last_seq + 24'd1;
      seq_back = !first && seq <= last_seq;
   end
   // skip holds idx at 0 for a frame already in flight when reset released
   always_ff @(posedge clk125MHz or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         seq      <= '0;
         last_seq <= '0;
         prev_en  <= 1'b0;
         skip     <= 1'b1;
         first    <= 1'b1;
         countp   <= '0;
         okp      <= '0;
         started  <= 1'b0;
         finished <= 1'b0;
         valid    <= 1'b0;
      end else begin
         prev_en <= rx_en;
         skip    <= skip && rx_en;
         idx     <= !rx_en ? '0 : (skip || idx == SAT) ? idx : idx + 1'b1;
         if (in_seq) seq <= {seq[15:0], rx_data};
         valid <= accept;
         if (accept) begin
            countp   <= inc(countp);
            if (seq_ok) okp <= inc(okp);
            if (seq_back) finished <= 1'b1;
            last_seq <= seq;
            started  <= 1'b1;
            first    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rx_seq_log.sv
// tb_rx_seq_log: directed frames against rx_seq_log (CNT_W=32 and a CNT_W=4 copy sharing inputs).
module tb_rx_seq_log;
   logic        clk = 0, rst = 0, rx_en = 0;
   logic [7:0]  rx_data = 0;
   logic [31:0] countp, okp;
   logic [3:0]  s_countp, s_okp;
   logic        started, finished, valid, s_started, s_finished, s_valid;
   int          checks = 0, errors = 0, vcnt = 0, v0;
   rx_seq_log dut (.clk125MHz(clk), .rst(rst), .rx_en(rx_en), .rx_data(rx_data),
      .countp(countp), .okp(okp), .started(started), .finished(finished), .valid(valid));
   rx_seq_log #(.CNT_W(4)) dut4 (.clk125MHz(clk), .rst(rst), .rx_en(rx_en), .rx_data(rx_data),
      .countp(s_countp), .okp(s_okp), .started(s_started), .finished(s_finished), .valid(s_valid));
   always #4 clk = ~clk;
   always @(negedge clk) if (valid) vcnt++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] bval(input logic [23:0] s, input int i);
      return i == 3 ? s[23:16] : i == 4 ? s[15:8] : i == 5 ? s[7:0] : 8'hDE;
   endfunction
   task automatic bytes(input logic [23:0] s, input int from, input int to);
      for (int i = from; i < to; i++) begin
         @(negedge clk);
         rx_en   = 1;
         rx_data = bval(s, i);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_en   = 0;
         rx_data = 0;
      end
   endtask
   task automatic frame(input logic [23:0] s, input int len = 30);
      bytes(s, 0, len);
      idle(4);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst   = 1;
      rx_en = 0;
      idle(2);
      rst = 0;
      idle(2);
   endtask
   initial begin
      do_reset();
      chk("rst_countp", countp, 0);
      chk("rst_okp", okp, 0);
      chk("rst_started", 32'(started), 0);
      chk("rst_finished", 32'(finished), 0);
      chk("rst_valid", 32'(valid), 0);
      bytes(24'd0, 0, 30);
      idle(1);
      chk("pre_valid", 32'(valid), 0);
      idle(1);
      chk("lat_valid", 32'(valid), 1);
      chk("lat_countp", countp, 1);
      idle(1);
      chk("valid_pulse", 32'(valid), 0);
      idle(2);
      for (int i = 1; i < 40; i++) frame(24'(i));
      chk("run_countp", countp, 40);
      chk("run_okp", okp, 40);
      chk("run_started", 32'(started), 1);
      chk("run_finished", 32'(finished), 0);
      chk("run_vcnt", vcnt, 40);
      frame(24'd30);
      chk("back_countp", countp, 41);
      chk("back_okp", okp, 40);
      chk("back_finished", 32'(finished), 1);
      for (int i = 0; i < 39; i++) frame(24'd30);
      chk("frozen_countp", countp, 41);
      chk("frozen_vcnt", vcnt, 41);
      do_reset();
      frame(24'd0); frame(24'd1); frame(24'd3); frame(24'd4);
      chk("gap_countp", countp, 4);
      chk("gap_okp", okp, 3);
      chk("gap_finished", 32'(finished), 0);
      do_reset();
      v0 = vcnt;
      frame(24'd0);
      frame(24'd1, 5);
      frame(24'd1);
      chk("runt_countp", countp, 2);
      chk("runt_okp", okp, 2);
      chk("runt_vcnt", vcnt - v0, 2);
      frame(24'd2, 6);
      chk("minlen_countp", countp, 3);
      chk("minlen_okp", okp, 3);
      bytes(24'd9, 0, 10);
      rst = 1;
      #1;
      chk("async_countp", countp, 0);
      chk("async_okp", okp, 0);
      chk("async_started", 32'(started), 0);
      @(negedge clk);
      rst = 0;
      bytes(24'd9, 10, 30);
      idle(4);
      chk("partial_countp", countp, 0);
      frame(24'd7);
      chk("after_countp", countp, 1);
      chk("after_okp", okp, 1);
      chk("after_started", 32'(started), 1);
      do_reset();
      frame(24'hFFFFFF); frame(24'h000000);
      chk("wrap_countp", countp, 2);
      chk("wrap_okp", okp, 2);
      chk("wrap_finished", 32'(finished), 1);
      do_reset();
      for (int i = 0; i < 17; i++) frame(24'(i));
`ifdef LOG_SATURATE_EN
      chk("w4_countp", 32'(s_countp), 15);
      chk("w4_okp", 32'(s_okp), 15);
`else
      chk("w4_countp", 32'(s_countp), 1);
      chk("w4_okp", 32'(s_okp), 1);
`endif
      chk("w4_finished", 32'(s_finished), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
